// File: rtl/rr_grant_fsm.sv
// Three-requester round-robin arbiter with a bounded hold time per grant.
// A mandatory one-cycle RECOVER state separates consecutive grants.
module rr_grant_fsm #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout,
  output logic       state_err
);

  // Plain vector rather than an enum so the unused 2'b11 code can be recognised.
  localparam logic [1:0] StIdle    = 2'b00;
  localparam logic [1:0] StGrant   = 2'b01;
  localparam logic [1:0] StRecover = 2'b10;

  localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic       err_q, err_d;

  logic [1:0] winner;
  logic       owner_req;
  logic       hold_limit;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Search order starts one past the most recent owner.
  always_comb begin
    logic [1:0] p0, p1, p2;
    p0 = next_idx(last_q);
    p1 = next_idx(p0);
    p2 = next_idx(p1);
    winner = p2;
    if (req[p1]) winner = p1;
    if (req[p0]) winner = p0;
  end

  assign owner_req  = req[owner_q];
  assign hold_limit = (cnt_q == HoldLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= 3'b000;
      owner_q   <= 2'd0;
      last_q    <= 2'd2;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (|req) state_d = StGrant;
      StGrant:   if (!owner_req || hold_limit) state_d = StRecover;
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d     = 3'b000;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d   = 3'b001 << winner;
          owner_d = winner;
          cnt_d   = 4'd0;
        end
      end
      StGrant: begin
        // Release wins over expiry, so timeout only fires while still requested.
        if (owner_req) begin
          if (hold_limit) begin
            timeout_d = 1'b1;
          end else begin
            gnt_d = gnt_q;
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
          end
        end
      end
      StRecover: last_d = owner_q;
      default:   err_d = 1'b1;
    endcase
    busy_d = |gnt_d;
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign state_err = err_q;

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Directed bench for rr_grant_fsm with MAX_HOLD=4; outputs sampled on the falling edge.
module tb_rr_grant_fsm;

  localparam int unsigned MaxHold = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;
  logic       state_err;

  int total = 0;
  int bad   = 0;

  logic [2:0] g_seq [4];
  logic [1:0] o_seq [4];

  always #5 clk = ~clk;

  rr_grant_fsm #(
    .MAX_HOLD(MaxHold)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .owner    (owner),
    .busy     (busy),
    .timeout  (timeout),
    .state_err(state_err)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [2:0] g, input logic [1:0] o,
                     input logic to, input logic se);
    logic [7:0] obs;
    logic [7:0] exp_v;
    obs   = {gnt, owner, busy, timeout, state_err};
    exp_v = {g, o, |g, to, se};
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s gnt/owner/busy/timeout/state_err got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
             tag, gnt, owner, busy, timeout, state_err, g, o, |g, to, se);
    end
  endtask

  initial begin
    g_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    o_seq = '{2'd0, 2'd1, 2'd2, 2'd0};
    rst = 1'b1;
    req = 3'b000;
    @(negedge clk);
    step();
    chk("reset", 3'b000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk("idle_no_req", 3'b000, 2'd0, 1'b0, 1'b0);

    // All three requesting: rotate 0,1,2,0 with a timeout after each grant.
    req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < int'(MaxHold); c++) begin
        step();
        chk("rr_hold", g_seq[r], o_seq[r], 1'b0, 1'b0);
      end
      step();
      chk("rr_timeout", 3'b000, o_seq[r], 1'b1, 1'b0);
      if (r == 3) req = 3'b000;
      step();
      chk("rr_gap", 3'b000, o_seq[r], 1'b0, 1'b0);
    end
    step();
    chk("rr_quiet", 3'b000, 2'd0, 1'b0, 1'b0);

    // Short request from requester 1 released before the limit.
    req = 3'b010;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("short_hold", 3'b010, 2'd1, 1'b0, 1'b0);
    end
    req = 3'b000;
    step();
    chk("short_recover", 3'b000, 2'd1, 1'b0, 1'b0);
    step();
    chk("short_idle", 3'b000, 2'd1, 1'b0, 1'b0);

    // Owner drops on its last allowed cycle: release, no timeout.
    req = 3'b001;
    for (int c = 0; c < int'(MaxHold); c++) begin
      step();
      chk("edge_hold", 3'b001, 2'd0, 1'b0, 1'b0);
    end
    req = 3'b000;
    step();
    chk("edge_release", 3'b000, 2'd0, 1'b0, 1'b0);
    step();
    chk("edge_idle", 3'b000, 2'd0, 1'b0, 1'b0);

    // Sole requester times out and is granted again.
    req = 3'b001;
    for (int c = 0; c < int'(MaxHold); c++) begin
      step();
      chk("sole_hold", 3'b001, 2'd0, 1'b0, 1'b0);
    end
    step();
    chk("sole_timeout", 3'b000, 2'd0, 1'b1, 1'b0);
    step();
    chk("sole_gap", 3'b000, 2'd0, 1'b0, 1'b0);
    step();
    chk("sole_regrant", 3'b001, 2'd0, 1'b0, 1'b0);

    // Move the grant to requester 2, then reset in the middle of it.
    req = 3'b100;
    step();
    chk("to2_recover", 3'b000, 2'd0, 1'b0, 1'b0);
    step();
    chk("to2_idle", 3'b000, 2'd0, 1'b0, 1'b0);
    step();
    chk("to2_grant", 3'b100, 2'd2, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk("rst_mid_grant", 3'b000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 3'b101;
    step();
    chk("post_rst_first", 3'b001, 2'd0, 1'b0, 1'b0);

    // Illegal state encoding recovers to IDLE with a single error pulse.
    force dut.state_q = 2'b11;
    #1;
    release dut.state_q;
    step();
    chk("illegal_state", 3'b000, 2'd0, 1'b0, 1'b1);
    step();
    chk("illegal_resume", 3'b001, 2'd0, 1'b0, 1'b0);
    req = 3'b000;
    step();
    chk("final_recover", 3'b000, 2'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
